sccb_cfg_sequencer: RTL and testbench
=====================================

Name: sccb_cfg_sequencer

Overview:
- Parametrised successor to the camera I2C/SCCB register-init sequencer.
- Walks an external synchronous config ROM of {sub_addr, data} entries and issues one write transaction per entry to the existing I2C_Controller-style engine through a GO/END/ACK handshake.
- Adds what the previous block lacked: configurable address/data widths, a bounded retry count, error reporting, inline delay entries and re-triggerable runs.
- Sits between the camera top level and the I2C engine; oDONE replaces cmos_finish.

Parameters:
- SLAVE_ADDR, 8'h42, 8-bit write address of the sensor.
- SUB_W, 8, sub-address width in bits (8 or 16).
- DAT_W, 8, register data width in bits (8 or 16).
- LUT_SIZE, 164, number of ROM entries to execute (indices 0..LUT_SIZE-1).
- IDX_W, 8, ROM index width; must satisfy 2**IDX_W >= LUT_SIZE.
- MAX_RETRY, 3, re-attempts allowed per entry after a NACK.
- DELAY_CYCLES, 100000, iCLK cycles per delay unit (1 ms at 100 MHz).
- DELAY_SUB, all-ones, sub-address value that marks a delay entry.

Ports:
- iCLK  in  1  system clock
- iRST  in  1  asynchronous active-high reset
- iSTART  in  1  one-cycle pulse that re-runs the table from index 0; ignored while busy
- oROM_ADDR  out  IDX_W  config ROM index
- iROM_DATA  in  SUB_W+DAT_W  ROM entry {sub_addr, data}, valid one cycle after oROM_ADDR
- oI2C_DATA  out  8+SUB_W+DAT_W  {SLAVE_ADDR, sub_addr, data} to the I2C engine
- oI2C_GO  out  1  transaction request (level)
- iI2C_END  in  1  transaction finished (level, synchronous to iCLK)
- iI2C_ACK  in  1  1 = NACK seen during the transaction, 0 = success
- oBUSY  out  1  run in progress
- oDONE  out  1  sticky; table completed without error
- oERROR  out  1  sticky; retries exhausted
- oERR_INDEX  out  IDX_W  index of the failing entry

Behaviour:
- Reset values: all outputs 0; state FETCH (a run starts automatically on reset release); index 0; retry count 0.
- States: IDLE, FETCH, LATCH, ISSUE, WAIT_END, WAIT_REL, DELAY, NEXT.
- FETCH: drive oROM_ADDR = index. Next state is LATCH.
- LATCH: capture iROM_DATA.
  - If sub_addr == DELAY_SUB and the delay feature is enabled, load the delay counter with data*DELAY_CYCLES and go to DELAY.
  - Otherwise, load oI2C_DATA and go to ISSUE.
- ISSUE: wait until iI2C_END == 0, then set oI2C_GO = 1 and go to WAIT_END.
- WAIT_END:
  - oI2C_GO is held at 1 until iI2C_END == 1 is seen; on that cycle drop GO and sample iI2C_ACK.
  - ACK == 0: go to NEXT.
  - ACK == 1 and retry count < MAX_RETRY: increment the retry count and go to WAIT_REL, then reissue the same entry.
  - ACK == 1 and retries exhausted: set oERROR = 1 and oERR_INDEX = index, clear oBUSY, go to IDLE.
- WAIT_REL: wait until iI2C_END == 0, then go to ISSUE.
- DELAY: decrement the counter to 0, then go to NEXT. A delay value of 0 passes through in one cycle.
- NEXT: clear the retry count.
  - If index == LUT_SIZE-1: set oDONE = 1, clear oBUSY, go to IDLE.
  - Otherwise, increment index and go to FETCH.
- oBUSY = 1 in every state except IDLE.
- iSTART in IDLE: clear oDONE, oERROR and oERR_INDEX, set index to 0, go to FETCH.
- iSTART in any other state: no effect.
- Width rules:
  - The delay counter is 32 bits; the data*DELAY_CYCLES product saturates at all-ones.
  - Index arithmetic never wraps because it is bounded by LUT_SIZE-1.
- Reset mid-transaction: GO drops immediately (asynchronous) and the run restarts from index 0 after release.

Optional Feature:
- Macro: CFG_DELAY_EN.
- Defined: entries whose sub_addr equals DELAY_SUB insert a data*DELAY_CYCLES wait and generate no bus traffic.
- Undefined: the DELAY state and counter are not built, and such entries are written to the sensor like any other entry.

Decomposition:
- Package cfg_seq_pkg holds:
  - the state enum;
  - the entry struct {sub, dat} parameterised by SUB_W/DAT_W via localparams;
  - default SLAVE_ADDR and DELAY_SUB constants.
- One natural sub-module: cfg_delay_timer (load, count, zero flag), instantiated only under CFG_DELAY_EN.

Test Plan:
- Nominal run: LUT_SIZE=4 ROM {1234, 0A55, 1100, 3A04}, model always ACKs 0 -> exactly 4 GO pulses with oI2C_DATA = 42_12_34, 42_0A_55, 42_11_00, 42_3A_04; then oDONE = 1 and oBUSY = 0.
- Retry: model NACKs entry 1 twice, then ACKs -> entry 1 is issued 3 times, the run completes, and oERROR stays 0.
- Error: model NACKs entry 2 always, MAX_RETRY=3 -> 4 attempts, then oERROR = 1, oERR_INDEX = 2, no further GO, oDONE = 0.
- Delay (CFG_DELAY_EN): entry FF_05 with DELAY_CYCLES=10 -> no GO for 50 cycles (±2), then the next entry is issued.
- Restart: after DONE, pulse iSTART -> oDONE clears within 1 cycle and the full table is re-executed. An iSTART pulsed mid-run is ignored.
- Async reset asserted during WAIT_END -> oI2C_GO = 0 in the same cycle; after release, the first transaction uses index 0.

Source files
------------

// File: rtl/cfg_seq_pkg.sv
// Shared types and defaults for the SCCB configuration sequencer.
// Optional inline-delay support is enabled with the CFG_DELAY_EN macro.
package cfg_seq_pkg;

  localparam logic [7:0] DEF_SLAVE_ADDR = 8'h42;
  localparam int         DEF_SUB_W      = 8;
  localparam int         DEF_DAT_W      = 8;
  localparam logic [DEF_SUB_W-1:0] DEF_DELAY_SUB = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_ISSUE,
    ST_WAIT_END,
    ST_WAIT_REL,
    ST_DELAY,
    ST_NEXT
  } cfg_state_t;

  typedef struct packed {
    logic [DEF_SUB_W-1:0] sub;
    logic [DEF_DAT_W-1:0] dat;
  } cfg_entry_t;

  // 32x32 multiply clamped to 32 bits, used to size delay entries.
  function automatic logic [31:0] sat_mul32(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    prod = {32'd0, a} * {32'd0, b};
    return (|prod[63:32]) ? 32'hFFFF_FFFF : prod[31:0];
  endfunction

endpackage

// File: rtl/cfg_delay_timer.sv
// Down-counter for inline delay entries: load a 32-bit count, decrement while
// enabled, report when it has reached zero. Only built under CFG_DELAY_EN.
module cfg_delay_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        count,
  output logic        zero
);

  logic [31:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (count && (cnt != 32'd0)) begin
      cnt <= cnt - 32'd1;
    end
  end

  assign zero = (cnt == 32'd0);

endmodule

// File: rtl/sccb_cfg_sequencer.sv
// Walks a synchronous {sub_addr, data} config ROM and issues one SCCB write per
// entry with bounded NACK retries. CFG_DELAY_EN adds inline delay entries.
module sccb_cfg_sequencer
  import cfg_seq_pkg::*;
#(
  parameter logic [7:0]       SLAVE_ADDR   = DEF_SLAVE_ADDR,
  parameter int               SUB_W        = 8,
  parameter int               DAT_W        = 8,
  parameter int               LUT_SIZE     = 164,
  parameter int               IDX_W        = 8,
  parameter int               MAX_RETRY    = 3,
  parameter int               DELAY_CYCLES = 100000,
  parameter logic [SUB_W-1:0] DELAY_SUB    = '1
) (
  input  logic                     iCLK,
  input  logic                     iRST,
  input  logic                     iSTART,
  output logic [IDX_W-1:0]         oROM_ADDR,
  input  logic [SUB_W+DAT_W-1:0]   iROM_DATA,
  output logic [8+SUB_W+DAT_W-1:0] oI2C_DATA,
  output logic                     oI2C_GO,
  input  logic                     iI2C_END,
  input  logic                     iI2C_ACK,
  output logic                     oBUSY,
  output logic                     oDONE,
  output logic                     oERROR,
  output logic [IDX_W-1:0]         oERR_INDEX
);

  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LUT_SIZE - 1);
  localparam logic [RW-1:0]    RETRY_MAX = RW'(MAX_RETRY);

  typedef struct packed {
    logic [SUB_W-1:0] sub;
    logic [DAT_W-1:0] dat;
  } entry_t;

  entry_t                     entry;
  cfg_state_t                 state;
  logic [IDX_W-1:0]           index;
  logic [RW-1:0]              retry;
  logic                       go;
  logic                       busy;
  logic                       done;
  logic                       error;
  logic [IDX_W-1:0]           err_index;
  logic [8+SUB_W+DAT_W-1:0]   i2c_data;
  logic                       is_delay;

  assign entry = iROM_DATA;

`ifdef CFG_DELAY_EN
  logic        dly_zero;
  logic [31:0] dly_val;

  assign is_delay = (entry.sub == DELAY_SUB);
  assign dly_val  = sat_mul32(32'(entry.dat), 32'(DELAY_CYCLES));

  cfg_delay_timer u_delay (
    .clk      (iCLK),
    .rst      (iRST),
    .load     ((state == ST_LATCH) && is_delay),
    .load_val (dly_val),
    .count    (state == ST_DELAY),
    .zero     (dly_zero)
  );
`else
  // Delay entries are ordinary writes here; the delay parameters only fold
  // into a sink so they stay referenced.
  logic unused_delay_cfg;
  assign is_delay         = 1'b0;
  assign unused_delay_cfg = ^{DELAY_SUB, 32'(DELAY_CYCLES)};
`endif

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state     <= ST_FETCH;
      index     <= '0;
      retry     <= '0;
      go        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_index <= '0;
      i2c_data  <= '0;
    end else begin
      // busy tracks whether the state being entered is anything but IDLE
      busy <= 1'b1;
      case (state)
        ST_IDLE: begin
          busy <= iSTART;
          if (iSTART) begin
            done      <= 1'b0;
            error     <= 1'b0;
            err_index <= '0;
            index     <= '0;
            retry     <= '0;
            state     <= ST_FETCH;
          end
        end
        ST_FETCH: state <= ST_LATCH;
        ST_LATCH: begin
          if (is_delay) begin
            state <= ST_DELAY;
          end else begin
            i2c_data <= {SLAVE_ADDR, entry.sub, entry.dat};
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!iI2C_END) begin
            go    <= 1'b1;
            state <= ST_WAIT_END;
          end
        end
        ST_WAIT_END: begin
          if (iI2C_END) begin
            go <= 1'b0;
            if (!iI2C_ACK) begin
              state <= ST_NEXT;
            end else if (retry < RETRY_MAX) begin
              retry <= retry + 1'b1;
              state <= ST_WAIT_REL;
            end else begin
              error     <= 1'b1;
              err_index <= index;
              busy      <= 1'b0;
              state     <= ST_IDLE;
            end
          end
        end
        ST_WAIT_REL: if (!iI2C_END) state <= ST_ISSUE;
`ifdef CFG_DELAY_EN
        ST_DELAY: if (dly_zero) state <= ST_NEXT;
`endif
        ST_NEXT: begin
          retry <= '0;
          if (index == LAST_IDX) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            index <= index + 1'b1;
            state <= ST_FETCH;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign oROM_ADDR  = index;
  assign oI2C_DATA  = i2c_data;
  assign oI2C_GO    = go;
  assign oBUSY      = busy;
  assign oDONE      = done;
  assign oERROR     = error;
  assign oERR_INDEX = err_index;

endmodule

// File: tb/tb_sccb_cfg_sequencer.sv
// Directed bench for sccb_cfg_sequencer: nominal run, retry, error, delay
// entry (behaviour depends on CFG_DELAY_EN), restart and async reset.
module tb_sccb_cfg_sequencer;
  import cfg_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic [23:0] i2c_data;
  logic        i2c_go;
  logic        i2c_end;
  logic        i2c_ack;
  logic        busy;
  logic        done;
  logic        error;
  logic [7:0]  err_index;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sccb_cfg_sequencer #(
    .SLAVE_ADDR   (8'h42),
    .SUB_W        (8),
    .DAT_W        (8),
    .LUT_SIZE     (4),
    .IDX_W        (8),
    .MAX_RETRY    (3),
    .DELAY_CYCLES (10)
  ) dut (
    .iCLK       (clk),
    .iRST       (rst),
    .iSTART     (start),
    .oROM_ADDR  (rom_addr),
    .iROM_DATA  (rom_data),
    .oI2C_DATA  (i2c_data),
    .oI2C_GO    (i2c_go),
    .iI2C_END   (i2c_end),
    .iI2C_ACK   (i2c_ack),
    .oBUSY      (busy),
    .oDONE      (done),
    .oERROR     (error),
    .oERR_INDEX (err_index)
  );

  // Synchronous config ROM
  cfg_entry_t rom [0:3];
  always @(posedge clk) rom_data <= (rom_addr < 8'd4) ? rom[rom_addr[1:0]] : 16'h0000;

  // I2C engine model: END after 4 busy cycles, held until GO drops.
  int          go_count = 0;
  logic [23:0] log_data [0:63];
  logic        go_q;
  int          busy_cnt;
  int          nack_given = 0;
  int          nack_limit = 0;
  logic [23:0] nack_data = 24'h0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      i2c_end    <= 1'b0;
      i2c_ack    <= 1'b0;
      busy_cnt   <= 0;
      go_q       <= 1'b0;
      nack_given <= 0;
    end else begin
      go_q <= i2c_go;
      if (i2c_go && !go_q) begin
        log_data[go_count[5:0]] <= i2c_data;
        go_count <= go_count + 1;
      end
      if (i2c_end) begin
        if (!i2c_go) i2c_end <= 1'b0;
      end else if (i2c_go) begin
        if (busy_cnt == 3) begin
          i2c_end  <= 1'b1;
          busy_cnt <= 0;
          if (i2c_data == nack_data && nack_given < nack_limit) begin
            i2c_ack    <= 1'b1;
            nack_given <= nack_given + 1;
          end else begin
            i2c_ack <= 1'b0;
          end
        end else begin
          busy_cnt <= busy_cnt + 1;
        end
      end
      if (start) nack_given <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (busy) check(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_go(input string tag, input int target);
    int n = 0;
    while (go_count < target && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (go_count < target) check(tag, 32'(go_count), 32'(target));
  endtask

  task automatic check_log(input string tag, input int idx, input logic [23:0] exp);
    check(tag, 32'(log_data[idx[5:0]]), 32'(exp));
  endtask

  initial begin
    int base;
    int n;
    int go_at;

    rom[0] = 16'h1234;
    rom[1] = 16'h0A55;
    rom[2] = 16'h1100;
    rom[3] = 16'h3A04;

    // Reset state
    tick(3);
    check("rst_go", 32'(i2c_go), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_err_index", 32'(err_index), 32'd0);
    check("rst_i2c_data", 32'(i2c_data), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    rst = 1'b0;

    // Nominal run starts automatically on reset release
    tick(2);
    check("auto_run_busy", 32'(busy), 32'd1);
    wait_idle("nominal_timeout");
    check("nominal_go_count", 32'(go_count), 32'd4);
    check_log("nominal_tx0", 0, 24'h421234);
    check_log("nominal_tx1", 1, 24'h420A55);
    check_log("nominal_tx2", 2, 24'h421100);
    check_log("nominal_tx3", 3, 24'h423A04);
    check("nominal_done", 32'(done), 32'd1);
    check("nominal_busy", 32'(busy), 32'd0);
    check("nominal_error", 32'(error), 32'd0);

    // Restart with two NACKs on entry 1; a mid-run start is ignored
    nack_data  = 24'h420A55;
    nack_limit = 2;
    base = go_count;
    pulse_start();
    check("restart_done_clear", 32'(done), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    wait_go("restart_first_go", base + 1);
    pulse_start();
    wait_idle("retry_timeout");
    check("retry_go_count", 32'(go_count - base), 32'd6);
    check_log("retry_tx0", base + 0, 24'h421234);
    check_log("retry_tx1", base + 1, 24'h420A55);
    check_log("retry_tx2", base + 2, 24'h420A55);
    check_log("retry_tx3", base + 3, 24'h420A55);
    check_log("retry_tx4", base + 4, 24'h421100);
    check_log("retry_tx5", base + 5, 24'h423A04);
    check("retry_done", 32'(done), 32'd1);
    check("retry_error", 32'(error), 32'd0);

    // Entry 2 always NACKs: 1 + 3 retries, then error
    nack_data  = 24'h421100;
    nack_limit = 100;
    base = go_count;
    pulse_start();
    wait_idle("error_timeout");
    check("error_go_count", 32'(go_count - base), 32'd6);
    check_log("error_attempt1", base + 2, 24'h421100);
    check_log("error_attempt4", base + 5, 24'h421100);
    check("error_flag", 32'(error), 32'd1);
    check("error_index", 32'(err_index), 32'd2);
    check("error_done", 32'(done), 32'd0);
    tick(30);
    check("error_no_more_go", 32'(go_count - base), 32'd6);
    check("error_idle_busy", 32'(busy), 32'd0);

    // Delay-marker entry FF_05
    rom[2]     = 16'hFF05;
    nack_limit = 0;
    base = go_count;
    pulse_start();
    check("start_clears_error", 32'(error), 32'd0);
    check("start_clears_err_index", 32'(err_index), 32'd0);
`ifdef CFG_DELAY_EN
    n = 0;
    while (rom_addr != 8'd2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("delay_reach_entry2", 32'(rom_addr), 32'd2);
    go_at = go_count;
    n = 0;
    while (rom_addr == 8'd2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    // 50 delay cycles plus FETCH/LATCH/zero-exit/NEXT overhead of about 4
    check("delay_dwell_in_window", 32'(n >= 52 && n <= 56), 32'd1);
    check("delay_no_go", 32'(go_count - go_at), 32'd0);
    wait_idle("delay_timeout");
    check("delay_go_count", 32'(go_count - base), 32'd3);
    check_log("delay_next_entry", base + 2, 24'h423A04);
`else
    go_at = 0;
    n = 0;
    wait_idle("delay_timeout");
    check("nodelay_go_count", 32'(go_count - base), 32'd4);
    check_log("nodelay_marker_written", base + 2, 24'h42FF05);
    check_log("nodelay_last_entry", base + 3, 24'h423A04);
`endif
    check("delay_run_done", 32'(done), 32'd1);

    // Async reset while GO is asserted
    rom[2] = 16'h1100;
    base = go_count;
    pulse_start();
    wait_go("areset_reach_tx1", base + 2);
    check("areset_go_before", 32'(i2c_go), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("areset_go_drop", 32'(i2c_go), 32'd0);
    check("areset_busy_drop", 32'(busy), 32'd0);
    check("areset_rom_addr", 32'(rom_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    base = go_count;
    wait_go("areset_first_go", base + 1);
    check_log("areset_first_tx", base, 24'h421234);
    wait_idle("areset_timeout");
    check("areset_done", 32'(done), 32'd1);
    check("areset_go_count", 32'(go_count - base), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
